del_node_conn_stream: RTL and testbench

//  Streaming genome-pruning stage for the NEAT mutation pipeline; successor to the single-shot node/conn delete lane.

---
 rtl/neat_gene_pkg.sv | 19 +
 rtl/del_list_cam.sv | 45 ++++
 rtl/del_node_conn_stream.sv | 136 +++++++++++++
 tb/tb_del_node_conn_stream.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/neat_gene_pkg.sv
// Shared NEAT gene definitions: field positions (in units of ATTR_SZ), node type codes
// and the pruning-stage state encoding.
package neat_gene_pkg;

  // Type field MSB sits at TYPE_WORD*ATTR_SZ-2; id/src and dest occupy whole attribute words
  localparam int TYPE_WORD = 7;
  localparam int ID_WORD   = 5;
  localparam int DEST_WORD = 4;

  localparam logic [1:0] NODE_HIDDEN = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_NODES = 2'd1,
    ST_CONNS = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

endpackage

// File: rtl/del_list_cam.sv
// Deletion list: DEL_DEPTH id/valid slots with one indexed write port and a
// combinational dual-id (src, dest) match against all valid entries.
module del_list_cam #(
  parameter int ATTR_SZ   = 8,
  parameter int DEL_DEPTH = 8,
  parameter int IDX_W     = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_idx,
  input  logic [ATTR_SZ-1:0] wr_id,
  input  logic [ATTR_SZ-1:0] src_id,
  input  logic [ATTR_SZ-1:0] dest_id,
  output logic               match
);

  logic [ATTR_SZ-1:0]   ids [DEL_DEPTH];
  logic [DEL_DEPTH-1:0] vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
      for (int i = 0; i < DEL_DEPTH; i++) ids[i] <= '0;
    end else begin
      for (int i = 0; i < DEL_DEPTH; i++) begin
        if (clr) begin
          vld[i] <= 1'b0;
        end else if (wr_en && (wr_idx == IDX_W'(i))) begin
          ids[i] <= wr_id;
          vld[i] <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    match = 1'b0;
    for (int i = 0; i < DEL_DEPTH; i++) begin
      if (vld[i] && ((ids[i] == src_id) || (ids[i] == dest_id))) match = 1'b1;
    end
  end

endmodule

// File: rtl/del_node_conn_stream.sv
// Streaming genome pruner: deletes hidden nodes into a deletion list, then drops connections
// touching deleted nodes (plus random drops), with a single-register valid/ready output.
module del_node_conn_stream
  import neat_gene_pkg::*;
#(
  parameter int GENE_SZ   = 64,
  parameter int ATTR_SZ   = 8,
  parameter int DEL_DEPTH = 8,
  parameter int CNT_SZ    = 16,
  localparam int DN_W     = $clog2(DEL_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [ATTR_SZ-1:0] node_del_prob,
  input  logic [ATTR_SZ-1:0] conn_del_prob,
  input  logic [1:0]         mode,
  input  logic [ATTR_SZ-1:0] random,
  input  logic [GENE_SZ-1:0] in_gene,
  input  logic               in_valid,
  input  logic               in_last,
  output logic               in_ready,
  output logic [GENE_SZ-1:0] out_gene,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy,
  output logic               done,
  output logic [DN_W-1:0]    del_node_cnt,
  output logic [CNT_SZ-1:0]  del_conn_cnt
);

  function automatic logic [CNT_SZ-1:0] sat_inc(input logic [CNT_SZ-1:0] v);
    return (&v) ? v : v + CNT_SZ'(1);
  endfunction

  state_t state, state_nxt;
  logic   done_nxt;

  logic [ATTR_SZ-1:0] node_prob_r, conn_prob_r;
  logic [1:0]         mode_r;

  logic [1:0]         node_type;
  logic [ATTR_SZ-1:0] gene_src, gene_dest;
  logic               accept, start_go, node_del, conn_drop, cam_match;
  logic               node_del_acc, conn_drop_acc, keep_acc;

  assign node_type = in_gene[TYPE_WORD*ATTR_SZ-2 -: 2];
  assign gene_src  = in_gene[(ID_WORD+1)*ATTR_SZ-1 -: ATTR_SZ];
  assign gene_dest = in_gene[(DEST_WORD+1)*ATTR_SZ-1 -: ATTR_SZ];

  assign busy     = (state != ST_IDLE);
  assign in_ready = ((state == ST_NODES) || (state == ST_CONNS)) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign start_go = (state == ST_IDLE) && start;

  // Full list lets further hidden nodes pass untouched
  assign node_del = (state == ST_NODES) && mode_r[0] && (node_type == NODE_HIDDEN) &&
                    (random < node_prob_r) && (del_node_cnt < DN_W'(DEL_DEPTH));
  assign conn_drop = (state == ST_CONNS) &&
                     (cam_match || (mode_r[1] && (random < conn_prob_r)));

  assign node_del_acc  = accept && node_del;
  assign conn_drop_acc = accept && conn_drop;
  assign keep_acc      = accept && !node_del && !conn_drop;

  del_list_cam #(
    .ATTR_SZ  (ATTR_SZ),
    .DEL_DEPTH(DEL_DEPTH),
    .IDX_W    (DN_W)
  ) u_cam (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (start_go),
    .wr_en  (node_del_acc),
    .wr_idx (del_node_cnt),
    .wr_id  (gene_src),
    .src_id (gene_src),
    .dest_id(gene_dest),
    .match  (cam_match)
  );

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_NODES;
      ST_NODES: if (accept && in_last) state_nxt = ST_CONNS;
      ST_CONNS: if (accept && in_last) state_nxt = ST_DRAIN;
      ST_DRAIN: begin
        if (!out_valid) begin
          done_nxt  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      done         <= 1'b0;
      node_prob_r  <= '0;
      conn_prob_r  <= '0;
      mode_r       <= '0;
      del_node_cnt <= '0;
      del_conn_cnt <= '0;
      out_gene     <= '0;
      out_valid    <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= done_nxt;

      if (start_go) begin
        node_prob_r <= node_del_prob;
        conn_prob_r <= conn_del_prob;
        mode_r      <= mode;
      end

      if (start_go)          del_node_cnt <= '0;
      else if (node_del_acc) del_node_cnt <= del_node_cnt + DN_W'(1);

      if (start_go)           del_conn_cnt <= '0;
      else if (conn_drop_acc) del_conn_cnt <= sat_inc(del_conn_cnt);

      // A dropped gene is only accepted when the register is empty or draining, so it clears here
      if (keep_acc) begin
        out_gene  <= in_gene;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_del_node_conn_stream.sv
// Directed bench for del_node_conn_stream (DEL_DEPTH=4): node/conn pruning, list full,
// backpressure, random conn drops, mid-genome reset and ignored start.
module tb_del_node_conn_stream;

  localparam int GENE_SZ   = 64;
  localparam int ATTR_SZ   = 8;
  localparam int DEL_DEPTH = 4;
  localparam int CNT_SZ    = 16;
  localparam int DN_W      = $clog2(DEL_DEPTH + 1);

  logic               clk;
  logic               rst_n;
  logic               start;
  logic [ATTR_SZ-1:0] node_del_prob, conn_del_prob, rnd;
  logic [1:0]         mode;
  logic [GENE_SZ-1:0] in_gene, out_gene;
  logic               in_valid, in_last, in_ready, out_valid, out_ready, busy, done;
  logic [DN_W-1:0]    del_node_cnt;
  logic [CNT_SZ-1:0]  del_conn_cnt;

  del_node_conn_stream #(
    .GENE_SZ  (GENE_SZ),
    .ATTR_SZ  (ATTR_SZ),
    .DEL_DEPTH(DEL_DEPTH),
    .CNT_SZ   (CNT_SZ)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .node_del_prob(node_del_prob),
    .conn_del_prob(conn_del_prob),
    .mode         (mode),
    .random       (rnd),
    .in_gene      (in_gene),
    .in_valid     (in_valid),
    .in_last      (in_last),
    .in_ready     (in_ready),
    .out_gene     (out_gene),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .busy         (busy),
    .done         (done),
    .del_node_cnt (del_node_cnt),
    .del_conn_cnt (del_conn_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  int          done_seen = 0;
  logic [63:0] got_q[$];
  logic [63:0] exp_q[$];

  always @(negedge clk) begin
    if (out_valid && out_ready) got_q.push_back(out_gene);
    if (done) done_seen++;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mk(input logic [1:0] t, input logic [7:0] a, input logic [7:0] b);
    logic [63:0] g;
    g = '0;
    g[54:53] = t;
    g[47:40] = a;
    g[39:32] = b;
    g[7:0]   = a ^ b ^ 8'h5A;
    return g;
  endfunction

  task automatic send(input logic [63:0] g, input logic [7:0] r, input logic last);
    logic ok;
    in_gene  = g;
    rnd      = r;
    in_last  = last;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
    end
    if (!ok) check_eq("send_timeout", 64'(ok), 64'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic begin_genome(input logic [7:0] np, input logic [7:0] cp, input logic [1:0] md);
    got_q.delete();
    exp_q.delete();
    node_del_prob = np;
    conn_del_prob = cp;
    mode          = md;
    start         = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done();
    logic ok;
    ok = 1'b0;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      if (done) ok = 1'b1;
    end
    if (!ok) check_eq("done_timeout", 64'(ok), 64'(1));
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag);
    logic [63:0] g;
    check_eq({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      g = 'x;
      if (i < got_q.size()) g = got_q[i];
      check_eq(tag, g, exp_q[i]);
    end
  endtask

  initial begin
    int d0;
    rst_n = 1'b0; start = 1'b0; node_del_prob = '0; conn_del_prob = '0; mode = '0;
    rnd = '0; in_gene = '0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_busy", 64'(busy), 64'(0));
    check_eq("rst_outv", 64'(out_valid), 64'(0));
    check_eq("rst_inrdy", 64'(in_ready), 64'(0));
    check_eq("rst_done", 64'(done), 64'(0));
    check_eq("rst_ncnt", 64'(del_node_cnt), 64'(0));
    check_eq("rst_ccnt", 64'(del_conn_cnt), 64'(0));
    @(posedge clk);
    #1;

    // 1: two hidden nodes deleted, conn touching node 5 dropped
    begin_genome(8'h80, 8'h80, 2'b01);
    check_eq("t1_busy", 64'(busy), 64'(1));
    send(mk(2'b00, 8'd5, 8'd0), 8'h10, 1'b0);
    send(mk(2'b00, 8'd6, 8'd0), 8'h10, 1'b1);
    send(mk(2'b00, 8'd5, 8'd9), 8'h10, 1'b0);
    send(mk(2'b00, 8'd2, 8'd3), 8'h10, 1'b1);
    wait_done();
    exp_q.push_back(mk(2'b00, 8'd2, 8'd3));
    check_out("t1_out");
    check_eq("t1_ncnt", 64'(del_node_cnt), 64'(2));
    check_eq("t1_ccnt", 64'(del_conn_cnt), 64'(1));
    check_eq("t1_idle", 64'(busy), 64'(0));

    // 2: list fills at 4, input node passes, conn to deleted node 10 dropped
    begin_genome(8'h80, 8'h00, 2'b01);
    for (int k = 0; k < 6; k++) send(mk(2'b00, 8'(10 + k), 8'd0), 8'h00, 1'b0);
    send(mk(2'b01, 8'd1, 8'd0), 8'h00, 1'b1);
    send(mk(2'b00, 8'd10, 8'd21), 8'h00, 1'b0);
    send(mk(2'b00, 8'd20, 8'd21), 8'h00, 1'b1);
    wait_done();
    exp_q.push_back(mk(2'b00, 8'd14, 8'd0));
    exp_q.push_back(mk(2'b00, 8'd15, 8'd0));
    exp_q.push_back(mk(2'b01, 8'd1, 8'd0));
    exp_q.push_back(mk(2'b00, 8'd20, 8'd21));
    check_out("t2_out");
    check_eq("t2_ncnt", 64'(del_node_cnt), 64'(4));
    check_eq("t2_ccnt", 64'(del_conn_cnt), 64'(1));

    // 3: output stalled 5 cycles mid-stream
    begin_genome(8'h00, 8'h00, 2'b00);
    out_ready = 1'b0;
    send(mk(2'b00, 8'd30, 8'd0), 8'h00, 1'b0);
    in_gene = mk(2'b00, 8'd31, 8'd0);
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_eq("t3_inrdy", 64'(in_ready), 64'(0));
      check_eq("t3_outv", 64'(out_valid), 64'(1));
      check_eq("t3_hold", out_gene, mk(2'b00, 8'd30, 8'd0));
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    send(mk(2'b00, 8'd31, 8'd0), 8'h00, 1'b0);
    send(mk(2'b00, 8'd32, 8'd0), 8'h00, 1'b1);
    send(mk(2'b00, 8'd33, 8'd34), 8'h00, 1'b0);
    send(mk(2'b00, 8'd35, 8'd36), 8'h00, 1'b1);
    wait_done();
    exp_q.push_back(mk(2'b00, 8'd30, 8'd0));
    exp_q.push_back(mk(2'b00, 8'd31, 8'd0));
    exp_q.push_back(mk(2'b00, 8'd32, 8'd0));
    exp_q.push_back(mk(2'b00, 8'd33, 8'd34));
    exp_q.push_back(mk(2'b00, 8'd35, 8'd36));
    check_out("t3_out");

    // 4: random conn drops only, alternating random around 8'h40
    d0 = done_seen;
    begin_genome(8'h00, 8'h40, 2'b10);
    send(mk(2'b01, 8'd1, 8'd0), 8'h00, 1'b1);
    for (int k = 0; k < 6; k++)
      send(mk(2'b00, 8'(40 + k), 8'(50 + k)), (k % 2 == 0) ? 8'h10 : 8'hF0, k == 5);
    wait_done();
    repeat (3) @(posedge clk);
    #1;
    exp_q.push_back(mk(2'b01, 8'd1, 8'd0));
    for (int k = 1; k < 6; k += 2) exp_q.push_back(mk(2'b00, 8'(40 + k), 8'(50 + k)));
    check_out("t4_out");
    check_eq("t4_ccnt", 64'(del_conn_cnt), 64'(3));
    check_eq("t4_ncnt", 64'(del_node_cnt), 64'(0));
    check_eq("t4_done_once", 64'(done_seen - d0), 64'(1));

    // 5: reset during CONNS, then a fresh genome sees an empty list
    begin_genome(8'h80, 8'h80, 2'b01);
    send(mk(2'b00, 8'd7, 8'd0), 8'h00, 1'b1);
    send(mk(2'b00, 8'd60, 8'd61), 8'hF0, 1'b0);
    rst_n = 1'b0;
    #1;
    check_eq("t5_busy", 64'(busy), 64'(0));
    check_eq("t5_outv", 64'(out_valid), 64'(0));
    check_eq("t5_outg", out_gene, 64'(0));
    check_eq("t5_inrdy", 64'(in_ready), 64'(0));
    check_eq("t5_ncnt", 64'(del_node_cnt), 64'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;
    begin_genome(8'h80, 8'h80, 2'b01);
    send(mk(2'b00, 8'd8, 8'd0), 8'hF0, 1'b1);
    send(mk(2'b00, 8'd7, 8'd8), 8'h00, 1'b1);
    wait_done();
    exp_q.push_back(mk(2'b00, 8'd8, 8'd0));
    exp_q.push_back(mk(2'b00, 8'd7, 8'd8));
    check_out("t5_out");
    check_eq("t5_ncnt2", 64'(del_node_cnt), 64'(0));
    check_eq("t5_ccnt2", 64'(del_conn_cnt), 64'(0));

    // 6: second start during NODES must not relatch probs/mode
    begin_genome(8'h80, 8'h80, 2'b01);
    node_del_prob = 8'h00;
    mode = 2'b00;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check_eq("t6_busy", 64'(busy), 64'(1));
    send(mk(2'b00, 8'd9, 8'd0), 8'h10, 1'b1);
    send(mk(2'b00, 8'd70, 8'd71), 8'h00, 1'b1);
    wait_done();
    exp_q.push_back(mk(2'b00, 8'd70, 8'd71));
    check_out("t6_out");
    check_eq("t6_ncnt", 64'(del_node_cnt), 64'(1));

    // 7: zero node probability never deletes
    begin_genome(8'h00, 8'h00, 2'b01);
    send(mk(2'b00, 8'd3, 8'd0), 8'h00, 1'b1);
    send(mk(2'b00, 8'd3, 8'd4), 8'h00, 1'b1);
    wait_done();
    exp_q.push_back(mk(2'b00, 8'd3, 8'd0));
    exp_q.push_back(mk(2'b00, 8'd3, 8'd4));
    check_out("t7_out");
    check_eq("t7_ncnt", 64'(del_node_cnt), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
